// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider: one quotient bit per cycle after St is accepted in IDLE.
// Latency: Done pulses N+1 cycles after acceptance (1 cycle on divide-by-zero); one divide per N+2 cycles.
// Backpressure: none; St is only sampled in IDLE and requests seen while busy are dropped.
module shift_sub_divider #(
    parameter int N = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         St,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Idle,
    output logic         Done,
    output logic         DivByZero
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N:0]    r;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] count;

    logic [N:0]    t_r;
    logic [N:0]    diff;
    logic          fits;
    logic [N:0]    r_nxt;
    logic [N-1:0]  q_nxt;
    logic          zero_div;
    logic          last_iter;

    assign zero_div  = (Divisor == '0);
    assign last_iter = (count == LAST);

    // Shift {R,Q} left one place and try to subtract the divisor from the upper half.
    always_comb begin
        t_r   = {r[N-1:0], q[N-1]};
        diff  = t_r - {1'b0, d};
        fits  = ~diff[N];
        r_nxt = fits ? diff : t_r;
        q_nxt = {q[N-2:0], fits};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (St) begin
                    state_nxt = zero_div ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign Idle = (state == S_IDLE);
    assign Done = (state == S_DONE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            count     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (St) begin
                        if (zero_div) begin
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivByZero <= 1'b1;
                        end else begin
                            q         <= Dividend;
                            d         <= Divisor;
                            r         <= '0;
                            count     <= '0;
                            DivByZero <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r     <= r_nxt;
                    q     <= q_nxt;
                    count <= count + CW'(1);
                    // Publish on the final iteration so results are valid throughout DONE.
                    if (last_iter) begin
                        Quotient  <= q_nxt;
                        Remainder <= r_nxt[N-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: directed scenarios plus a random sweep against arithmetic / and %.
module tb_shift_sub_divider;

    localparam int N = 8;
    localparam int TMO = 40;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         St = 1'b0;
    logic [N-1:0] Dividend = '0;
    logic [N-1:0] Divisor = '0;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         Idle;
    logic         Done;
    logic         DivByZero;

    int n_tests = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    shift_sub_divider #(.N(N)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .St(St),
        .Dividend(Dividend),
        .Divisor(Divisor),
        .Quotient(Quotient),
        .Remainder(Remainder),
        .Idle(Idle),
        .Done(Done),
        .DivByZero(DivByZero)
    );

    // Starts a divide and reports what was observed; lat counts cycles from the accepting edge to Done.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, output int lat,
                           output logic [N-1:0] q, output logic [N-1:0] r, output logic z,
                           output logic idle_after, output logic done_after, output logic both_hi);
        int w;
        w = 0;
        while (Idle !== 1'b1 && w < TMO) begin
            @(posedge Clk); #1; w++;
        end
        @(negedge Clk);
        Dividend = a;
        Divisor  = b;
        St       = 1'b1;
        @(posedge Clk); #1;
        St      = 1'b0;
        lat     = 1;
        both_hi = 1'b0;
        while (Done !== 1'b1 && lat < TMO) begin
            both_hi = both_hi | (Idle & Done);
            @(posedge Clk); #1; lat++;
        end
        both_hi    = both_hi | (Idle & Done);
        q          = Quotient;
        r          = Remainder;
        z          = DivByZero;
        @(posedge Clk); #1;
        idle_after = Idle;
        done_after = Done;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        St  = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        St  = 1'b0;
        n_tests++;
        if ({Idle, Done} !== 2'b10) begin
            $display("FAIL reset_flags: Idle/Done=%b expected 10", {Idle, Done}); n_fail++;
        end
        n_tests++;
        if ({Quotient, Remainder, DivByZero} !== '0) begin
            $display("FAIL reset_outputs: Q=%0d R=%0d Z=%b expected 0 0 0", Quotient, Remainder, DivByZero); n_fail++;
        end
    endtask

    task automatic test_basic();
        int lat; logic [N-1:0] q, r; logic z, ia, da, bh;
        run_div(8'd100, 8'd7, lat, q, r, z, ia, da, bh);
        n_tests++;
        if (lat !== N + 1) begin
            $display("FAIL basic_latency: got %0d expected %0d", lat, N + 1); n_fail++;
        end
        n_tests++;
        if ({q, r, z} !== {8'd14, 8'd2, 1'b0}) begin
            $display("FAIL basic_result: Q=%0d R=%0d Z=%b expected 14 2 0", q, r, z); n_fail++;
        end
        n_tests++;
        if ({ia, da, bh} !== 3'b100) begin
            $display("FAIL basic_after_done: Idle=%b Done=%b overlap=%b expected 1 0 0", ia, da, bh); n_fail++;
        end
        repeat (3) @(posedge Clk);
        #1;
        n_tests++;
        if ({Quotient, Remainder, Done} !== {8'd14, 8'd2, 1'b0}) begin
            $display("FAIL basic_hold: Q=%0d R=%0d Done=%b expected 14 2 0", Quotient, Remainder, Done); n_fail++;
        end
    endtask

    task automatic test_boundary();
        logic [N-1:0] ta [4], tb [4], tq [4], tr [4];
        int lat; logic [N-1:0] q, r; logic z, ia, da, bh;
        ta = '{8'd255, 8'd5, 8'd255, 8'd0};
        tb = '{8'd1,   8'd9, 8'd255, 8'd3};
        tq = '{8'd255, 8'd0, 8'd1,   8'd0};
        tr = '{8'd0,   8'd5, 8'd0,   8'd0};
        for (int i = 0; i < 4; i++) begin
            run_div(ta[i], tb[i], lat, q, r, z, ia, da, bh);
            n_tests++;
            if ({q, r, z} !== {tq[i], tr[i], 1'b0} || lat !== N + 1) begin
                $display("FAIL boundary_%0d/%0d: Q=%0d R=%0d Z=%b lat=%0d expected %0d %0d 0 lat %0d",
                         ta[i], tb[i], q, r, z, lat, tq[i], tr[i], N + 1); n_fail++;
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat; logic [N-1:0] q, r; logic z, ia, da, bh;
        run_div(8'd200, 8'd0, lat, q, r, z, ia, da, bh);
        n_tests++;
        if (lat !== 1) begin
            $display("FAIL dbz_latency: got %0d expected 1", lat); n_fail++;
        end
        n_tests++;
        if ({q, r, z} !== {8'd255, 8'd200, 1'b1}) begin
            $display("FAIL dbz_result: Q=%0d R=%0d Z=%b expected 255 200 1", q, r, z); n_fail++;
        end
        n_tests++;
        if ({ia, da, bh} !== 3'b100) begin
            $display("FAIL dbz_after_done: Idle=%b Done=%b overlap=%b expected 1 0 0", ia, da, bh); n_fail++;
        end
        run_div(8'd9, 8'd3, lat, q, r, z, ia, da, bh);
        n_tests++;
        if ({q, r, z} !== {8'd3, 8'd0, 1'b0} || lat !== N + 1) begin
            $display("FAIL dbz_recover: Q=%0d R=%0d Z=%b lat=%0d expected 3 0 0 lat %0d", q, r, z, lat, N + 1); n_fail++;
        end
    endtask

    task automatic test_busy();
        int cyc, first_done, second_done;
        first_done  = 0;
        second_done = 0;
        @(negedge Clk);
        Dividend = 8'd100;
        Divisor  = 8'd7;
        St       = 1'b1;
        @(posedge Clk); #1;
        cyc = 1;
        while (cyc < 3 * TMO && second_done == 0) begin
            if (Done === 1'b1) begin
                if (first_done == 0) begin
                    first_done = cyc;
                    n_tests++;
                    if ({Quotient, Remainder} !== {8'd14, 8'd2}) begin
                        $display("FAIL busy_result: Q=%0d R=%0d expected 14 2", Quotient, Remainder); n_fail++;
                    end
                    Dividend = 8'd50;
                    Divisor  = 8'd6;
                end else begin
                    second_done = cyc;
                end
            end else if (first_done == 0) begin
                Dividend = 8'($urandom);
                Divisor  = 8'($urandom);
            end
            @(posedge Clk); #1; cyc++;
        end
        St = 1'b0;
        n_tests++;
        if (first_done !== N + 1) begin
            $display("FAIL busy_first_done: cycle %0d expected %0d", first_done, N + 1); n_fail++;
        end
        // Re-acceptance at edge N+2 after the first acceptance puts the second Done at cycle 2N+3.
        n_tests++;
        if (second_done !== 2 * N + 3) begin
            $display("FAIL busy_reaccept: second Done at cycle %0d expected %0d", second_done, 2 * N + 3); n_fail++;
        end
        n_tests++;
        if ({Quotient, Remainder} !== {8'd8, 8'd2}) begin
            $display("FAIL busy_second_result: Q=%0d R=%0d expected 8 2", Quotient, Remainder); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [N-1:0] q, r; logic z, ia, da, bh, seen;
        int w;
        w = 0;
        while (Idle !== 1'b1 && w < TMO) begin
            @(posedge Clk); #1; w++;
        end
        @(negedge Clk);
        Dividend = 8'd100;
        Divisor  = 8'd7;
        St       = 1'b1;
        @(posedge Clk); #1;
        St = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
        end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        n_tests++;
        if ({Idle, Done, Quotient, Remainder, DivByZero} !== {1'b1, 1'b0, 17'd0}) begin
            $display("FAIL midreset_state: Idle=%b Done=%b Q=%0d R=%0d Z=%b expected 1 0 0 0 0",
                     Idle, Done, Quotient, Remainder, DivByZero); n_fail++;
        end
        seen = 1'b0;
        repeat (2 * N) begin
            @(posedge Clk); #1;
            seen = seen | Done;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            $display("FAIL midreset_no_done: Done seen=%b expected 0", seen); n_fail++;
        end
        run_div(8'd50, 8'd6, lat, q, r, z, ia, da, bh);
        n_tests++;
        if ({q, r, z} !== {8'd8, 8'd2, 1'b0} || lat !== N + 1) begin
            $display("FAIL midreset_after: Q=%0d R=%0d Z=%b lat=%0d expected 8 2 0 lat %0d", q, r, z, lat, N + 1); n_fail++;
        end
    endtask

    task automatic test_random();
        int lat; logic [N-1:0] q, r; logic z, ia, da, bh;
        int a, b, eq, er;
        for (int i = 0; i < 1000; i++) begin
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(1, 255));
            eq = a / b;
            er = a % b;
            run_div(8'(a), 8'(b), lat, q, r, z, ia, da, bh);
            n_tests++;
            if (int'(q) !== eq || int'(r) !== er || z !== 1'b0 || lat !== N + 1 ||
                ({ia, da, bh} !== 3'b100) || (int'(q) * b + int'(r) !== a) || !(int'(r) < b)) begin
                $display("FAIL random_%0d/%0d: Q=%0d R=%0d Z=%b lat=%0d after=%b%b%b expected %0d %0d 0 lat %0d after 100",
                         a, b, q, r, z, lat, ia, da, bh, eq, er, N + 1); n_fail++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_div_by_zero();
        test_busy();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
